// File: rtl/conv_pkg.sv
// Shared definitions for the conv2d weight loader: FSM encoding and weight-count derivation.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    PULSE_W = 3'd2,
    LOAD_B  = 3'd3,
    PULSE_B = 3'd4,
    DONE    = 3'd5
  } state_t;

  // Number of packed weight elements feeding conv2d weights_in.
  function automatic int calc_nw(input int nf, input int ic, input int kh, input int kw);
    return nf * ic * kh * kw;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/conv2d_weight_loader.sv
// Streams conv2d weights then biases from a serial valid/ready port into packed
// registers, issuing one-cycle commit strobes for each block and a done pulse.
module conv2d_weight_loader
  import conv_pkg::*;
#(
  parameter int NUM_FILTERS    = 32,
  parameter int INPUT_CHANNELS = 1,
  parameter int KERNEL_HEIGHT  = 3,
  parameter int KERNEL_WIDTH   = 3,
  parameter int ACTIV_BITS     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ACTIV_BITS-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [NUM_FILTERS*INPUT_CHANNELS*KERNEL_HEIGHT*KERNEL_WIDTH*ACTIV_BITS-1:0] weights_out,
  output logic [NUM_FILTERS*ACTIV_BITS-1:0] biases_out,
  output logic                  load_weights,
  output logic                  load_biases,
  output logic                  busy,
  output logic                  done
);

  localparam int NW = calc_nw(NUM_FILTERS, INPUT_CHANNELS, KERNEL_HEIGHT, KERNEL_WIDTH);
  localparam int CW = $clog2(max2(NW, NUM_FILTERS) + 1);
  localparam logic [CW-1:0] W_LAST = CW'(NW - 1);
  localparam logic [CW-1:0] B_LAST = CW'(NUM_FILTERS - 1);

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            xfer;

  logic [ACTIV_BITS-1:0] w_q [NW];
  logic [ACTIV_BITS-1:0] b_q [NUM_FILTERS];

  assign s_ready = (state == LOAD_W) || (state == LOAD_B);
  assign xfer    = s_valid & s_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    load_weights = 1'b0;
    load_biases  = 1'b0;
    done         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          cnt_d   = '0;
        end
      end
      LOAD_W: begin
        if (xfer) begin
          if (cnt == W_LAST) begin
            state_d = PULSE_W;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      PULSE_W: begin
        load_weights = 1'b1;
        state_d      = LOAD_B;
      end
      LOAD_B: begin
        if (xfer) begin
          if (cnt == B_LAST) begin
            state_d = PULSE_B;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt + CW'(1);
          end
        end
      end
      PULSE_B: begin
        load_biases = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Element registers only move on an accepted transfer; everything else holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NW; i++)          w_q[i] <= '0;
      for (int i = 0; i < NUM_FILTERS; i++) b_q[i] <= '0;
    end else if (xfer) begin
      for (int i = 0; i < NW; i++)
        if (state == LOAD_W && cnt == CW'(i)) w_q[i] <= s_data;
      for (int i = 0; i < NUM_FILTERS; i++)
        if (state == LOAD_B && cnt == CW'(i)) b_q[i] <= s_data;
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_wpack
    assign weights_out[g*ACTIV_BITS +: ACTIV_BITS] = w_q[g];
  end

  for (genvar g = 0; g < NUM_FILTERS; g++) begin : g_bpack
    assign biases_out[g*ACTIV_BITS +: ACTIV_BITS] = b_q[g];
  end

endmodule
